monitor_stream_sched: RTL
=========================

// Module: monitor_stream_sched
// PURPOSE
// Time-shares one automata monitor cluster (e.g. Automata_ltl5c4) among NUM_REQ symbol-stream requesters.
// Per frame: round-robin grant, one-cycle automaton clear (so start_of_data fires on the first symbol),
// stream symbols with am_run, then tag each non-zero report vector with source id and symbol offset.
// Tagged reports are buffered in a FIFO for the monitor aggregation logic.
// PARAMETERS
// NUM_REQ      4   number of symbol requesters (>=2)
// SYM_W        8   symbol width; matches automaton symbols input
// NUM_RPT      4   number of automaton report outputs
// OFFS_W       16  symbol-offset counter width
// RFIFO_DEPTH  4   report FIFO entries (power of 2, >=2)
// PORTS
// clk          in   1                clock
// reset_n      in   1                asynchronous active-low reset
// req_valid    in   NUM_REQ          requester i has a symbol
// req_sym      in   NUM_REQ*SYM_W    symbol of requester i, slice [i*SYM_W +: SYM_W]
// req_last     in   NUM_REQ          symbol is last of frame
// req_ready    out  NUM_REQ          symbol of requester i consumed this cycle
// am_reset     out  1                automaton reset (active high)
// am_run       out  1                automaton consumes am_symbols this cycle
// am_symbols   out  SYM_W            symbol to automaton
// am_report    in   NUM_RPT          automaton report outputs (valid 1 cycle after consume)
// rpt_valid    out  1                FIFO head valid
// rpt_ready    in   1                consumer pops head
// rpt_src      out  $clog2(NUM_REQ)  head source id
// rpt_vec      out  NUM_RPT          head report vector
// rpt_offset   out  OFFS_W           head symbol offset within frame
// busy         out  1                state != IDLE
// frame_done   out  1                1-cycle pulse when a frame fully drains
// BEHAVIOUR
// - Reset values: req_ready=0, am_reset=1, am_run=0, am_symbols=0, rpt_valid=0, busy=0, frame_done=0;
//   FIFO empty, rr_ptr=0, offset=0.
// - Asynchronous reset mid-frame aborts the frame; pending report is dropped; am_reset held high while asserted.
// - FSM states: IDLE, CLEAR, STREAM, DRAIN.
//   - IDLE: am_reset=1.
//     - Any req_valid: grant the lowest i >= rr_ptr (wrapping) with req_valid=1; latch gnt; go to CLEAR.
//   - CLEAR: am_reset=1 for exactly 1 cycle; offset<=0; then STREAM.
//   - STREAM: am_reset=0; am_symbols=req_sym[gnt].
//     - Consume iff req_valid[gnt] && credit>0, where credit = RFIFO_DEPTH - count - pend.
//       pend = report capture in flight; a pop in the same cycle does not add credit.
//     - Consume: am_run=1, req_ready[gnt]=1, offset++ (saturates at all-ones).
//     - No consume: am_run=0, automaton frozen, offset held.
//     - Consume with req_last=1: go to DRAIN.
//   - DRAIN: 1 cycle for the last report capture; pulse frame_done; rr_ptr<=gnt+1 (mod NUM_REQ); go to IDLE.
//   - Only gnt may see req_ready; other requesters wait, no preemption.
// - Report capture: cycle after a consume (pend=1), if |am_report, push {gnt, am_report, offset of that symbol}.
//   First symbol of a frame has offset 0. Zero vectors are never pushed.
// - Credit rule guarantees no FIFO overflow and no lost report; simultaneous push+pop on a full FIFO is legal.
// - FIFO output is first-word-fall-through; rpt_* are stable while rpt_valid && !rpt_ready.
// - Back-to-back frames: IDLE->CLEAR minimum 1 cycle, so each frame costs 3 cycles of overhead.
// - am_symbols=0 when not consuming, to avoid toggling.
// STRUCTURE
// - monitor_sched_pkg:
//   - sched_state_e {IDLE, CLEAR, STREAM, DRAIN}
//   - rpt_entry_t struct {src, vec, offset}, parameterised by localparams mirroring the defaults
// - Sub-module monitor_rpt_fifo: sync FIFO of rpt_entry_t.
//   - ports: push, pop, din, dout, count, full, empty
//   - async active-low reset
// - Top holds the FSM, round-robin pointer, offset counter, pend flop and credit check.
// TESTING
// 1. Reset then idle, no req_valid -> am_reset=1, rpt_valid=0, busy=0 indefinitely.
// 2. ltl5c4 attached; req0 sends {0x90 last} -> CLEAR 1 cycle, consume, rpt {src0, vec=4'b0001, off 0}, frame_done.
// 3. req1 and req3 valid together, rr_ptr=2 -> req3 granted first, then req1; req0/req2 never see req_ready.
// 4. rpt_ready=0, req0 streams 8 reporting symbols -> 4 reports queued, am_run stalls, none lost;
//    release rpt_ready -> offsets 0..7 in order.
// 5. reset_n low mid-STREAM at offset 3 -> outputs at reset values immediately;
//    next frame restarts at offset 0 with CLEAR.
// 6. req_valid gaps during a frame -> am_run low in gaps, offset counts consumed symbols only.

Source files
------------

// File: rtl/monitor_sched_pkg.sv
// rtl/monitor_sched_pkg.sv - shared types and default sizes for the monitor stream scheduler
// Purpose: FSM state enum and report-FIFO entry layout used by the scheduler and its FIFO.
// Contents: *_D localparams (default sizes), sched_state_e, rpt_entry_t {src, vec, offset}.
package monitor_sched_pkg;

  localparam int NUM_REQ_D     = 4;
  localparam int SYM_W_D       = 8;
  localparam int NUM_RPT_D     = 4;
  localparam int OFFS_W_D      = 16;
  localparam int RFIFO_DEPTH_D = 4;
  localparam int SRC_W_D       = $clog2(NUM_REQ_D);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } sched_state_e;

  // Entry field widths follow the *_D sizes above; the top must be built with matching sizes.
  typedef struct packed {
    logic [SRC_W_D-1:0]   src;
    logic [NUM_RPT_D-1:0] vec;
    logic [OFFS_W_D-1:0]  offset;
  } rpt_entry_t;

endpackage

// File: rtl/monitor_rpt_fifo.sv
// rtl/monitor_rpt_fifo.sv - synchronous first-word-fall-through FIFO of tagged report entries
// Purpose: buffers tagged automaton reports for the monitor aggregation logic.
// Ports: clk, reset_n (async active-low), push/din (write), pop/dout (FWFT head),
//        count (occupancy), full, empty.
module monitor_rpt_fifo
  import monitor_sched_pkg::*;
#(
  parameter int DEPTH = RFIFO_DEPTH_D
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  rpt_entry_t               din,
  output rpt_entry_t               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  rpt_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/monitor_stream_sched.sv
// rtl/monitor_stream_sched.sv - time-shares one automata monitor cluster among symbol requesters
// Purpose: round-robin frame grant, one-cycle automaton clear, credit-gated symbol streaming,
//          tagging of non-zero report vectors with source id and symbol offset.
// Ports: req_valid/req_sym/req_last/req_ready (requesters), am_reset/am_run/am_symbols/am_report
//        (automaton), rpt_valid/rpt_ready/rpt_src/rpt_vec/rpt_offset (report FIFO head),
//        busy, frame_done.
module monitor_stream_sched
  import monitor_sched_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_D,
  parameter int SYM_W       = SYM_W_D,
  parameter int NUM_RPT     = NUM_RPT_D,
  parameter int OFFS_W      = OFFS_W_D,
  parameter int RFIFO_DEPTH = RFIFO_DEPTH_D
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*SYM_W-1:0]   req_sym,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       am_reset,
  output logic                       am_run,
  output logic [SYM_W-1:0]           am_symbols,
  input  logic [NUM_RPT-1:0]         am_report,
  output logic                       rpt_valid,
  input  logic                       rpt_ready,
  output logic [$clog2(NUM_REQ)-1:0] rpt_src,
  output logic [NUM_RPT-1:0]         rpt_vec,
  output logic [OFFS_W-1:0]          rpt_offset,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RFIFO_DEPTH) + 1;

  sched_state_e      state, state_nxt;
  logic [SRC_W-1:0]  gnt;
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  pick;
  logic [SRC_W-1:0]  cand;
  logic              pick_found;
  logic [OFFS_W-1:0] offset;
  logic [OFFS_W-1:0] cap_offset;
  logic              pend;
  logic              consume;
  logic              has_credit;
  logic [CNT_W:0]    used;
  logic [SYM_W-1:0]  sym_sel;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rpt_push;
  rpt_entry_t        push_entry;
  rpt_entry_t        fifo_dout;

  // Lowest valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick       = rr_ptr;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  // A consumed symbol may still push a report next cycle, so the in-flight capture reserves
  // a slot; a pop in the same cycle is deliberately not counted as free space.
  assign used       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend};
  assign has_credit = !fifo_full && (used < (CNT_W+1)'(RFIFO_DEPTH));
  assign consume    = (state == STREAM) && req_valid[gnt] && has_credit;
  assign sym_sel    = req_sym[int'(gnt)*SYM_W +: SYM_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt        <= '0;
      rr_ptr     <= '0;
      offset     <= '0;
      cap_offset <= '0;
      pend       <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= consume;
      if (state == IDLE && pick_found) gnt <= pick;
      if (state == CLEAR) offset <= '0;
      if (consume) begin
        cap_offset <= offset;
        if (offset != '1) offset <= offset + OFFS_W'(1);
      end
      if (state == DRAIN) rr_ptr <= SRC_W'((int'(gnt) + 1) % NUM_REQ);
    end
  end

  always_comb begin
    state_nxt  = state;
    am_reset   = 1'b0;
    am_run     = 1'b0;
    req_ready  = '0;
    am_symbols = '0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        am_reset = 1'b1;
        if (pick_found) state_nxt = CLEAR;
      end
      CLEAR: begin
        am_reset  = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        if (consume) begin
          am_run         = 1'b1;
          req_ready[gnt] = 1'b1;
          am_symbols     = sym_sel;
          if (req_last[gnt]) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // The report of a consumed symbol is valid one cycle later; zero vectors carry no match.
  assign rpt_push          = pend && (|am_report);
  assign push_entry.src    = gnt;
  assign push_entry.vec    = am_report;
  assign push_entry.offset = cap_offset;

  monitor_rpt_fifo #(
    .DEPTH (RFIFO_DEPTH)
  ) u_rpt_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rpt_push),
    .pop     (rpt_ready),
    .din     (push_entry),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rpt_valid  = !fifo_empty;
  assign rpt_src    = fifo_dout.src;
  assign rpt_vec    = fifo_dout.vec;
  assign rpt_offset = fifo_dout.offset;

endmodule
